// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift/rotate, iterative shift-add MUL
// and restoring DIV, with valid/ready handshakes on both sides and one op in flight.
module alu_mc #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ctrl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             o,
   output logic             n,
   output logic             z,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0]     W_L   = (SHW + 1)'(WIDTH);
   localparam logic [SHW:0]     CNT_1 = (SHW + 1)'(1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUSY, S_DONE} state_e;

   typedef enum logic [3:0] {
      OP_MUL = 4'b0001,
      OP_DIV = 4'b0010,
      OP_ROL = 4'b1000,
      OP_ROR = 4'b1001,
      OP_SLL = 4'b1010,
      OP_SRL = 4'b1011,
      OP_OR  = 4'b1100,
      OP_AND = 4'b1101,
      OP_SUB = 4'b1110,
      OP_ADD = 4'b1111
   } op_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             o_q, o_d, n_q, n_d, z_q, z_d, err_q, err_d;

   // Single-cycle datapath, evaluated on the latched operands
   logic [WIDTH-1:0] add_sum, b_neg, sub_diff;
   logic [SHW-1:0]   sh;
   logic             sh_big;
   logic [WIDTH-1:0] alu_r;
   logic             alu_o, alu_err;

   always_comb begin
      add_sum  = a_q + b_q;
      b_neg    = ~b_q + ONE;
      sub_diff = a_q + b_neg;
      sh       = b_q[SHW-1:0];
      sh_big   = |b_q[WIDTH-1:SHW];
      alu_r    = '0;
      alu_o    = 1'b0;
      alu_err  = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_r = add_sum;
            alu_o = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = sub_diff;
            alu_o = (a_q[WIDTH-1] == b_neg[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND:  alu_r = a_q & b_q;
         OP_OR:   alu_r = a_q | b_q;
         OP_SLL:  alu_r = sh_big ? '0 : (a_q << sh);
         OP_SRL:  alu_r = sh_big ? '0 : (a_q >> sh);
         // A shift by WIDTH yields zero, so sh==0 needs no special case
         OP_ROL:  alu_r = (a_q << sh) | (a_q >> (W_L - {1'b0, sh}));
         OP_ROR:  alu_r = (a_q >> sh) | (a_q << (W_L - {1'b0, sh}));
         default: alu_err = 1'b1;
      endcase
   end

   // One iteration of shift-add multiply and of restoring divide
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, b_q};
      // The true difference is below b, so modulo-2^WIDTH subtraction is exact
      div_sub   = div_shift[WIDTH-1:0] - b_q;
   end

   logic [WIDTH-1:0] res;
   logic             res_o, res_err, load_res;

   // NOTE: every combinational output gets a default first, so no path leaves a latch.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      o_d      = o_q;
      n_d      = n_q;
      z_d      = z_q;
      err_d    = err_q;
      res      = '0;
      res_o    = 1'b0;
      res_err  = 1'b0;
      load_res = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = ctrl;
               hi_d    = '0;
               lo_d    = a;
               cnt_d   = '0;
               state_d = (ctrl == OP_MUL || ctrl == OP_DIV) ? S_BUSY : S_EXEC;
            end
         end
         S_EXEC: begin
            res      = alu_r;
            res_o    = alu_o;
            res_err  = alu_err;
            load_res = 1'b1;
            state_d  = S_DONE;
         end
         S_BUSY: begin
            if (cnt_q == W_L) begin
               load_res = 1'b1;
               state_d  = S_DONE;
               if (op_q == OP_MUL) begin
                  res   = lo_q;
                  res_o = |hi_q;
               end else if (b_q == '0) begin
                  res   = '1;
                  res_o = 1'b1;
               end else begin
                  res   = lo_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_1;
               if (op_q == OP_MUL) begin
                  {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
               end else begin
                  hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], div_ge};
               end
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (load_res) begin
         r_d   = res;
         o_d   = res_o;
         n_d   = res[WIDTH-1];
         z_d   = (res == '0);
         err_d = res_err;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         o_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         o_q     <= o_d;
         n_q     <= n_d;
         z_q     <= z_d;
         err_q   <= err_d;
      end
   end

   // NOTE: operand and iteration registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign r         = r_q;
   assign o         = o_q;
   assign n         = n_q;
   assign z         = z_q;
   assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;

   localparam logic [3:0] ADD = 4'b1111, SUB = 4'b1110, AND_ = 4'b1101, OR_ = 4'b1100;
   localparam logic [3:0] MUL = 4'b0001, DIV = 4'b0010;
   localparam logic [3:0] SLL = 4'b1010, SRL = 4'b1011, ROL = 4'b1000, ROR = 4'b1001;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic [3:0]  ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] r;
   logic        o, n, z, err;

   int checks = 0;
   int errors = 0;

   alu_mc #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ctrl(ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .o(o), .n(n), .z(z), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   // Present one op, scramble operands after the accept edge, count edges to out_valid.
   task automatic run_op(input logic [3:0] op, input logic [15:0] aa, input logic [15:0] bb,
                         output int lat);
      @(negedge clk);
      ctrl = op; a = aa; b = bb; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; ctrl = 4'b0111;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; ctrl = ADD; a = 16'h0001; b = 16'h0001; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, r, o, n, z, err} !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
         errors++;
         $display("FAIL reset_state got rdy=%b vld=%b r=%h onze=%b%b%b%b exp rdy=1 vld=0 r=0000 onze=0000",
                  in_ready, out_valid, r, o, n, z, err);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_add_sub_logic();
      logic [3:0]  op [9] = '{ADD, ADD, ADD, SUB, SUB, SUB, AND_, OR_, AND_};
      logic [15:0] ta [9] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h0005, 16'h8000, 16'h0003,
                              16'hF0F0, 16'hF0F0, 16'h00FF};
      logic [15:0] tb [9] = '{16'h0001, 16'h0001, 16'h8000, 16'h0005, 16'h0001, 16'h0005,
                              16'h0FF0, 16'h0F0F, 16'hFF00};
      logic [15:0] er [9] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'hFFFE,
                              16'h00F0, 16'hFFFF, 16'h0000};
      logic        eo [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 9; i++) begin
         run_op(op[i], ta[i], tb[i], lat);
         checks++;
         if ({r, o, n, z, err} !== {er[i], eo[i], er[i][15], er[i] == 16'h0, 1'b0} || lat != 1) begin
            errors++;
            $display("FAIL arith_logic[%0d] got r=%h onze=%b%b%b%b lat=%0d exp r=%h o=%b lat=1",
                     i, r, o, n, z, err, lat, er[i], eo[i]);
         end
         release_result();
      end
   endtask

   task automatic test_mul_div();
      logic [3:0]  op [6] = '{MUL, MUL, MUL, DIV, DIV, DIV};
      logic [15:0] ta [6] = '{16'h0003, 16'h0100, 16'hFFFF, 16'h0064, 16'h1234, 16'h0005};
      logic [15:0] tb [6] = '{16'h0004, 16'h0100, 16'hFFFF, 16'h0007, 16'h0000, 16'h0009};
      logic [15:0] er [6] = '{16'h000C, 16'h0000, 16'h0001, 16'h000E, 16'hFFFF, 16'h0000};
      logic        eo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(op[i], ta[i], tb[i], lat);
         checks++;
         if ({r, o, n, z, err} !== {er[i], eo[i], er[i][15], er[i] == 16'h0, 1'b0} || lat != 17) begin
            errors++;
            $display("FAIL mul_div[%0d] got r=%h onze=%b%b%b%b lat=%0d exp r=%h o=%b lat=17",
                     i, r, o, n, z, err, lat, er[i], eo[i]);
         end
         release_result();
      end
   endtask

   task automatic test_shift_rot();
      logic [3:0]  op [9] = '{ROL, ROR, SLL, SLL, SRL, SRL, ROL, ROR, ROL};
      logic [15:0] ta [9] = '{16'h8001, 16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF,
                              16'h1234, 16'h1234, 16'h8001};
      logic [15:0] tb [9] = '{16'h0001, 16'h0011, 16'h0010, 16'h000F, 16'h0004, 16'h0100,
                              16'h0000, 16'h0004, 16'h0021};
      logic [15:0] er [9] = '{16'h0003, 16'h8000, 16'h0000, 16'h8000, 16'h0800, 16'h0000,
                              16'h1234, 16'h4123, 16'h0003};
      int lat;
      for (int i = 0; i < 9; i++) begin
         run_op(op[i], ta[i], tb[i], lat);
         checks++;
         if ({r, o, n, z, err} !== {er[i], 1'b0, er[i][15], er[i] == 16'h0, 1'b0} || lat != 1) begin
            errors++;
            $display("FAIL shift_rot[%0d] got r=%h onze=%b%b%b%b lat=%0d exp r=%h o=0 lat=1",
                     i, r, o, n, z, err, lat, er[i]);
         end
         release_result();
      end
   endtask

   task automatic test_illegal();
      logic [3:0] op [3] = '{4'b0000, 4'b0011, 4'b0111};
      int lat;
      for (int i = 0; i < 3; i++) begin
         run_op(op[i], 16'hFFFF, 16'hFFFF, lat);
         checks++;
         if ({r, o, n, z, err} !== {16'h0000, 4'b0011} || lat != 1) begin
            errors++;
            $display("FAIL illegal[%0d] got r=%h onze=%b%b%b%b lat=%0d exp r=0000 onze=0011 lat=1",
                     i, r, o, n, z, err, lat);
         end
         release_result();
      end
      run_op(ADD, 16'h0001, 16'h0001, lat);
      checks++;
      if ({r, err} !== {16'h0002, 1'b0}) begin
         errors++;
         $display("FAIL err_clear got r=%h err=%b exp r=0002 err=0", r, err);
      end
      release_result();
   endtask

   task automatic test_hold();
      int lat;
      run_op(ADD, 16'h0001, 16'h0002, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; ctrl = SUB; a = 16'hFFFF; b = 16'h7FFF;
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, r, o, n, z, err} !== {1'b1, 1'b0, 16'h0003, 4'b0000}) begin
            errors++;
            $display("FAIL hold[%0d] got vld=%b rdy=%b r=%h onze=%b%b%b%b exp vld=1 rdy=0 r=0003 onze=0000",
                     i, out_valid, in_ready, r, o, n, z, err);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result();
      checks++;
      if ({out_valid, in_ready, r} !== {1'b0, 1'b1, 16'h0003}) begin
         errors++;
         $display("FAIL hold_release got vld=%b rdy=%b r=%h exp vld=0 rdy=1 r=0003",
                  out_valid, in_ready, r);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; ctrl = ADD; a = 16'h0010; b = 16'h0020;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept1 got rdy=%b exp 0", in_ready);
      end
      a = 16'h0100; b = 16'h0200;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, r} !== {1'b1, 16'h0030}) begin
         errors++;
         $display("FAIL b2b_result1 got vld=%b r=%h exp vld=1 r=0030", out_valid, r);
      end
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_idle got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept2 got rdy=%b exp 0", in_ready);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, r} !== {1'b1, 16'h0300}) begin
         errors++;
         $display("FAIL b2b_result2 got vld=%b r=%h exp vld=1 r=0300", out_valid, r);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_final_idle got rdy=%b exp 1", in_ready);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      @(negedge clk);
      in_valid = 1'b1; ctrl = MUL; a = 16'h00FF; b = 16'h00FF; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, r, o, n, z, err} !== {1'b1, 1'b0, 16'h0000, 4'b0000}) begin
         errors++;
         $display("FAIL reset_mid_mul got rdy=%b vld=%b r=%h onze=%b%b%b%b exp rdy=1 vld=0 r=0000 onze=0000",
                  in_ready, out_valid, r, o, n, z, err);
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_discard got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
      end
      run_op(MUL, 16'h0012, 16'h0034, lat);
      checks++;
      if ({r, o, n, z, err} !== {16'h03A8, 4'b0000} || lat != 17) begin
         errors++;
         $display("FAIL after_reset_mul got r=%h onze=%b%b%b%b lat=%0d exp r=03A8 onze=0000 lat=17",
                  r, o, n, z, err, lat);
      end
      release_result();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; ctrl = '0;
      test_reset();
      test_add_sub_logic();
      test_mul_div();
      test_shift_rot();
      test_illegal();
      test_hold();
      test_back_to_back();
      test_reset_mid_mul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
